nios2_led_fade_driver: RTL and testbench

//  Downstream stage of the LED PIO: consumes the 8-bit out_port pattern and drives the board

---
 rtl/nios2_led_fade_driver.sv | 137 +++++++++++++
 tb/tb_nios2_led_fade_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_led_fade_driver.sv
// LED fade driver: per-channel PWM whose duty ramps toward the PIO pattern; led/busy registered (1 clk), no backpressure.
// Define LED_FADE_SYNC_EN to pass pattern_in through a 2-flop synchroniser (+2 clk on pattern changes).
module nios2_led_fade_driver #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             enable,
  input  logic             bypass,
  output logic [WIDTH-1:0] led,
  output logic             busy
);

  localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam int unsigned MAX_I    = (2 ** PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] MAX_L = '1;
  // A step larger than the full range behaves like a full-range step; clamping keeps the sum inside PWM_BITS+1.
  localparam int unsigned STEP_SAT = (STEP > MAX_I) ? MAX_I : STEP;
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(STEP_SAT);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RISE,
    CH_ON,
    CH_FALL
  } ch_state_e;

  logic [WIDTH-1:0] pat_s;

`ifdef LED_FADE_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pattern_in;
      sync2_q <= sync1_q;
    end
  end

  assign pat_s = sync2_q;
`else
  assign pat_s = pattern_in;
`endif

  logic [PS_W-1:0]                   presc_q, presc_d;
  logic [PWM_BITS-1:0]               pwm_q, pwm_d;
  logic [WIDTH-1:0][PWM_BITS-1:0]    level_q, level_d;
  logic [WIDTH-1:0]                  led_q, led_d;
  logic                              busy_q, busy_d;
  logic [WIDTH-1:0]                  mism;
  logic                              tick;
  logic                              period_end;

  always_comb begin
    tick       = enable && (presc_q == PS_LAST);
    presc_d    = presc_q;
    pwm_d      = pwm_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      pwm_d = pwm_q + 1'b1;
    end
    period_end = tick && (pwm_q == MAX_L);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] lvl_nxt;
    logic [PWM_BITS:0]   sum_up;
    logic [PWM_BITS:0]   dif_dn;
    ch_state_e           st;

    assign tgt    = pat_s[i] ? MAX_L : '0;
    assign lvl    = level_q[i];
    assign sum_up = {1'b0, lvl} + STEP_W;
    assign dif_dn = {1'b0, lvl} - STEP_W;

    always_comb begin
      st = CH_OFF;
      if (lvl < tgt) begin
        st = CH_RISE;
      end else if (lvl > tgt) begin
        st = CH_FALL;
      end else if (lvl == MAX_L) begin
        st = CH_ON;
      end

      lvl_nxt = lvl;
      if (bypass) begin
        lvl_nxt = tgt;
      end else if (period_end) begin
        case (st)
          CH_RISE: lvl_nxt = (sum_up > {1'b0, MAX_L}) ? MAX_L : sum_up[PWM_BITS-1:0];
          CH_FALL: lvl_nxt = dif_dn[PWM_BITS] ? '0 : dif_dn[PWM_BITS-1:0];
          default: lvl_nxt = lvl;
        endcase
      end
    end

    assign level_d[i] = lvl_nxt;
    // Full level is forced on so MAX is a steady 1 rather than 15/16 duty.
    assign led_d[i]   = enable && ((lvl == MAX_L) || (lvl > pwm_q));
    assign mism[i]    = (lvl_nxt != tgt);
  end

  assign busy_d = |mism;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      pwm_q   <= '0;
      level_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      level_q <= level_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_nios2_led_fade_driver.sv
// Bench for nios2_led_fade_driver: PRESCALE=2, PWM_BITS=4, STEP=1 (plus a STEP=20 instance).
module tb_nios2_led_fade_driver;

  localparam int PS   = 2;
  localparam int MAXV = 15;
  localparam int STP  = 1;
  localparam int PER  = PS * (MAXV + 1);

  logic       clk;
  logic       reset;
  logic [7:0] pattern_in;
  logic       enable;
  logic       bypass;
  logic [7:0] led;
  logic       busy;

  logic [7:0] pattern2;
  logic       enable2;
  logic       bypass2;
  logic [7:0] led2;
  logic       busy2;

  int n_tests;
  int n_fail;

  nios2_led_fade_driver #(.WIDTH(8), .PRESCALE(PS), .PWM_BITS(4), .STEP(STP)) dut (
    .clk(clk), .reset(reset), .pattern_in(pattern_in), .enable(enable),
    .bypass(bypass), .led(led), .busy(busy)
  );

  nios2_led_fade_driver #(.WIDTH(8), .PRESCALE(PS), .PWM_BITS(4), .STEP(20)) dut_s20 (
    .clk(clk), .reset(reset), .pattern_in(pattern2), .enable(enable2),
    .bypass(bypass2), .led(led2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PWM position derived from the count of enabled cycles since reset.
  int         ecnt;
  int         lvl [8];
  logic [7:0] m_led;
  logic       m_busy;

  always @(posedge clk or posedge reset) begin
    int pwm;
    int tgt;
    bit pe;
    if (reset) begin
      ecnt   = 0;
      foreach (lvl[i]) lvl[i] = 0;
      m_led  = '0;
      m_busy = 1'b0;
    end else begin
      pwm = (ecnt / PS) % (MAXV + 1);
      pe  = enable && ((ecnt % PER) == PER - 1);
      for (int i = 0; i < 8; i++) m_led[i] = enable && (lvl[i] == MAXV || lvl[i] > pwm);
      m_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tgt = pattern_in[i] ? MAXV : 0;
        if (bypass) lvl[i] = tgt;
        else if (pe && lvl[i] < tgt) lvl[i] = (lvl[i] + STP > MAXV) ? MAXV : lvl[i] + STP;
        else if (pe && lvl[i] > tgt) lvl[i] = (lvl[i] - STP < 0) ? 0 : lvl[i] - STP;
        if (lvl[i] != tgt) m_busy = 1'b1;
      end
      if (enable) ecnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pat;
    logic       en;
    logic       byp;
    int         ncyc;
    logic [7:0] exp_led;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int highs;
    int other;
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    pattern_in = '0;
    enable     = 1'b0;
    bypass     = 1'b0;
    pattern2   = '0;
    enable2    = 1'b0;
    bypass2    = 1'b0;

    vecs[0] = '{8'h00, 1'b1, 1'b0,  5, 8'h00, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1,  2, 8'hA5, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b1,  1, 8'h00, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 1'b1,  2, 8'h00, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b1,  2, 8'h5A, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 40, 8'h5A, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0,  1, 8'h5A, 1'b1};
    vecs[7] = '{8'h00, 1'b1, 1'b1,  2, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_led_s20", 32'(led2), 32'h0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      pattern_in = vecs[v].pat;
      enable     = vecs[v].en;
      bypass     = vecs[v].byp;
      repeat (vecs[v].ncyc) @(negedge clk);
      chk($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Full rise of channel 0: duty grows 2 clk per period.
    pattern_in = '0; enable = 1'b0; bypass = 1'b0;
    do_reset();
    pattern_in = 8'h01; enable = 1'b1;
    highs = 0; other = 0;
    for (int e = 1; e <= 481; e++) begin
      @(negedge clk);
      if (e == 1)   chk("rise_busy_start", 32'(busy), 32'h1);
      if (e == 479) chk("rise_busy_late", 32'(busy), 32'h1);
      if (e == 480) chk("rise_busy_done", 32'(busy), 32'h0);
      if (led[0] && e <= 480) highs++;
      if (led[7:1] != 0) other++;
      if (e % PER == 0 && e <= 480) begin
        chk($sformatf("rise_duty_p%0d", e / PER - 1), 32'(highs), 32'(2 * (e / PER - 1)));
        highs = 0;
      end
    end
    chk("rise_led_full", 32'(led), 32'h01);
    chk("rise_other_bits", 32'(other), 32'h0);

    // Asynchronous reset with channel 0 fully on.
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led", 32'(led), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    pattern_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    other = 0;
    repeat (100) begin
      @(negedge clk);
      if (led != 0 || busy) other++;
    end
    chk("post_reset_quiet", 32'(other), 32'h0);

    // Rise to 8, then reverse down to 0.
    do_reset();
    pattern_in = 8'h01; enable = 1'b1;
    highs = 0;
    for (int e = 1; e <= 513; e++) begin
      @(negedge clk);
      if (e == 257) chk("rev_busy", 32'(busy), 32'h1);
      if (e >= 289 && e <= 320 && led[0]) highs++;
      if (e == 320) begin chk("rev_duty_l7", 32'(highs), 32'd14); highs = 0; end
      if (e >= 481 && e <= 512 && led[0]) highs++;
      if (e == 512) chk("rev_duty_l1", 32'(highs), 32'd2);
      if (e == 511) chk("rev_busy_late", 32'(busy), 32'h1);
      if (e == 512) chk("rev_busy_done", 32'(busy), 32'h0);
      if (e == 513) chk("rev_led_off", 32'(led), 32'h0);
      if (e == 256) pattern_in = 8'h00;
    end

    // Freeze at level 5 mid-period, then resume from the held PWM position.
    do_reset();
    pattern_in = 8'h01; enable = 1'b1;
    repeat (170) @(negedge clk);
    enable = 1'b0;
    highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (led != 0) highs++;
    end
    chk("freeze_led", 32'(highs), 32'h0);
    chk("freeze_busy", 32'(busy), 32'h1);
    enable = 1'b1;
    highs = 0;
    repeat (22) begin
      @(negedge clk);
      if (led[0]) highs++;
    end
    chk("resume_tail_l5", 32'(highs), 32'h0);
    highs = 0;
    repeat (32) begin
      @(negedge clk);
      if (led[0]) highs++;
    end
    chk("resume_duty_l6", 32'(highs), 32'd12);

    // STEP=20 instance saturates in one period_end each way.
    pattern_in = '0;
    do_reset();
    pattern2 = 8'hFF; enable2 = 1'b1;
    for (int e = 1; e <= 65; e++) begin
      @(negedge clk);
      if (e == 1)  chk("s20_busy_start", 32'(busy2), 32'h1);
      if (e == 31) chk("s20_busy_pre", 32'(busy2), 32'h1);
      if (e == 32) chk("s20_busy_sat", 32'(busy2), 32'h0);
      if (e == 33) chk("s20_led_on", 32'(led2), 32'hFF);
      if (e == 41) chk("s20_busy_fall", 32'(busy2), 32'h1);
      if (e == 63) chk("s20_busy_fall_pre", 32'(busy2), 32'h1);
      if (e == 64) chk("s20_busy_zero", 32'(busy2), 32'h0);
      if (e == 65) chk("s20_led_off", 32'(led2), 32'h0);
      if (e == 40) pattern2 = 8'h00;
    end
    enable2 = 1'b0;

    // Randomized run against the reference model.
    pattern_in = '0; enable = 1'b1; bypass = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      chk("rand_led", 32'(led), 32'(m_led));
      chk("rand_busy", 32'(busy), 32'(m_busy));
      if ($urandom_range(0, 149) == 0) pattern_in = 8'($urandom);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if (bypass) begin
        if ($urandom_range(0, 9) == 0) bypass = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        bypass = 1'b1;
      end
      reset = (cyc == 2000);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
